fp_div_arbiter: RTL and testbench

- Shares one combinational fp_div instance between NUM_REQ requesters, each with a valid/ready request port.
- Round-robin grant, one request per cycle.
- Registered response carries the quotient, the requester ID and a divide-by-zero flag, with a valid/ready output handshake.
- Sits between the per-lane issue logic and the single FPU divide datapath.

---
 rtl/fp_div_arbiter.sv | 155 +++++++++++++++
 tb/tb_fp_div_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision divider between
// NUM_REQ valid/ready requesters, with a one-entry registered response stage.

module fp_div (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);
  // Subnormal inputs read as zero; results below the normal range flush to signed zero.
  logic              s;
  logic [7:0]        ea, eb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [23:0]       na, nb;
  logic [25:0]       quo, rem;
  logic [23:0]       mant;
  logic [24:0]       mant_r;
  logic [22:0]       frac;
  logic              guard, sticky;
  logic signed [9:0] exp;

  always_comb begin
    s      = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    a_nan  = (ea == 8'hff) && (a[22:0] != '0);
    b_nan  = (eb == 8'hff) && (b[22:0] != '0);
    a_inf  = (ea == 8'hff) && (a[22:0] == '0);
    b_inf  = (eb == 8'hff) && (b[22:0] == '0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    na     = {1'b1, a[22:0]};
    nb     = {1'b1, b[22:0]};

    // Restoring division: 26 quotient bits of (na << 25) / nb.
    quo = '0;
    rem = {2'b00, na};
    for (int unsigned i = 0; i < 26; i++) begin
      if (rem >= {2'b00, nb}) begin
        quo = {quo[24:0], 1'b1};
        rem = rem - {2'b00, nb};
      end else begin
        quo = {quo[24:0], 1'b0};
      end
      rem = rem << 1;
    end

    exp = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
    if (quo[25]) begin
      mant   = quo[25:2];
      guard  = quo[1];
      sticky = quo[0] | (rem != '0);
    end else begin
      mant   = quo[24:1];
      guard  = quo[0];
      sticky = rem != '0;
      exp    = exp - 10'sd1;
    end

    mant_r = {1'b0, mant} + 25'(guard & (sticky | mant[0]));
    if (mant_r[24]) begin
      exp  = exp + 10'sd1;
      frac = '0;
    end else begin
      frac = mant_r[22:0];
    end

    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero))
      q = 32'h7fc00000;
    else if (a_inf || b_zero)
      q = {s, 8'hff, 23'h0};
    else if (a_zero || b_inf)
      q = {s, 31'h0};
    else if (exp >= 10'sd255)
      q = {s, 8'hff, 23'h0};
    else if (exp <= 10'sd0)
      q = {s, 31'h0};
    else
      q = {s, exp[7:0], frac};
  end
endmodule

module fp_div_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_operand_a,
  input  logic [NUM_REQ*32-1:0] req_operand_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_result,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_dz
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_id;
  logic            grant_any;
  logic            can_accept;
  int unsigned     idx;
  logic [31:0]     sel_a, sel_b, quotient;

  always_comb begin
    can_accept = (state == EMPTY) || rsp_ready;
    grant_any  = 1'b0;
    grant_id   = rr_ptr;
    idx        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx[ID_W-1:0];
      end
    end
    grant_any = grant_any && can_accept;

    req_ready = '0;
    if (grant_any && rst_n) req_ready[grant_id] = 1'b1;
  end

  assign sel_a     = req_operand_a[32*grant_id +: 32];
  assign sel_b     = req_operand_b[32*grant_id +: 32];
  assign rsp_valid = (state == FULL);

  fp_div u_fp_div (
    .a (sel_a),
    .b (sel_b),
    .q (quotient)
  );

  // A grant always loads the response stage, so drain-and-refill happens in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rr_ptr     <= '0;
      rsp_result <= '0;
      rsp_id     <= '0;
      rsp_dz     <= 1'b0;
    end else if (grant_any) begin
      state      <= FULL;
      rsp_result <= quotient;
      rsp_id     <= grant_id;
      rsp_dz     <= (sel_b[30:0] == '0);
      rr_ptr     <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed plus randomized bench for fp_div_arbiter against a reference model that
// divides in double precision and rounds to single.

module tb_fp_div_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_operand_a;
  logic [N*32-1:0] req_operand_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_result;
  logic [1:0]      rsp_id;
  logic            rsp_dz;

  int checks = 0;
  int errors = 0;

  bit          m_valid;
  logic [31:0] m_result;
  int          m_id;
  bit          m_dz;
  int          m_ptr;
  int          last_grant;
  logic [N-1:0] obs_ready;

  bit          lv[N];
  logic [31:0] la[N];
  logic [31:0] lb[N];

  fp_div_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_operand_a (req_operand_a),
    .req_operand_b (req_operand_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_id        (rsp_id),
    .rsp_dz        (rsp_dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic real to_real(input logic [31:0] x);
    return $bitstoreal({1'b0, 11'(int'(x[30:23]) + 896), x[22:0], 29'h0});
  endfunction

  // Quotient of two floats; subnormals treated as zero, underflow flushes to zero.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    bit          s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    real         qr;
    logic [63:0] d;
    logic [24:0] mant;
    logic [28:0] rest;
    int          e;
    s      = a[31] ^ b[31];
    a_nan  = a[30:23] == 8'hff && a[22:0] != 0;
    b_nan  = b[30:23] == 8'hff && b[22:0] != 0;
    a_inf  = a[30:23] == 8'hff && a[22:0] == 0;
    b_inf  = b[30:23] == 8'hff && b[22:0] == 0;
    a_zero = a[30:23] == 0;
    b_zero = b[30:23] == 0;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) return 32'h7fc00000;
    if (a_inf || b_zero) return {s, 8'hff, 23'h0};
    if (a_zero || b_inf) return {s, 31'h0};
    qr   = to_real(a) / to_real(b);
    d    = $realtobits(qr);
    e    = int'(d[62:52]) - 1023 + 127;
    mant = {2'b01, d[51:29]};
    rest = d[28:0];
    if (rest > 29'h10000000 || (rest == 29'h10000000 && mant[0])) mant = mant + 1;
    if (mant[24]) begin
      mant = mant >> 1;
      e++;
    end
    if (e >= 255) return {s, 8'hff, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 19))
      0:       r[30:0]  = '0;
      1:       r[30:0]  = {8'hff, 23'h0};
      2:       begin r[30:23] = 8'hff; r[22] = 1'b1; end
      3:       r[30:23] = 8'h00;
      4:       r[30:23] = 8'($urandom_range(1, 254));
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction

  // Lane closest to the pointer (in round-robin order) among the valid ones.
  function automatic int model_grant();
    int best = -1;
    int bestd = N;
    if (m_valid && !rsp_ready) return -1;
    for (int i = 0; i < N; i++) begin
      if (lv[i] && ((i - m_ptr + N) % N) < bestd) begin
        bestd = (i - m_ptr + N) % N;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_valid  = 0;
    m_result = '0;
    m_id     = 0;
    m_dz     = 0;
    m_ptr    = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]              = lv[i];
      req_operand_a[32*i +: 32] = la[i];
      req_operand_b[32*i +: 32] = lb[i];
    end
  endtask

  task automatic step();
    int          g;
    logic [31:0] exp_ready;
    @(negedge clk);
    g         = model_grant();
    obs_ready = req_ready;
    exp_ready = (g >= 0) ? (32'(1) << g) : 32'h0;
    check("req_ready", req_ready, exp_ready);
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_valid  = 1;
      m_result = ref_div(la[g], lb[g]);
      m_id     = g;
      m_dz     = (lb[g][30:0] == 0);
      m_ptr    = (g + 1) % N;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    last_grant = g;
    check("rsp_valid", rsp_valid, m_valid);
    check("rsp_result", rsp_result, m_result);
    check("rsp_id", rsp_id, m_id);
    check("rsp_dz", rsp_dz, m_dz);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", rsp_valid, 0);
    check("rst_result", rsp_result, 0);
    check("rst_id", rsp_id, 0);
    check("rst_dz", rsp_dz, 0);
    check("rst_ready", req_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] t2_b[4]   = '{32'h3f800000, 32'h40000000, 32'h3f000000, 32'h3f800000};
    logic [31:0] t2_res[4] = '{32'h3f800000, 32'h3f000000, 32'h40000000, 32'h3f800000};
    int          t5_ord[4] = '{1, 3, 1, 3};

    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      lv[i] = 0;
      la[i] = '0;
      lb[i] = '0;
    end
    lv[0] = 1;
    drive();
    do_reset();

    // Single request on lane 0.
    la[0] = 32'h3f800000; lb[0] = 32'h40000000;
    drive();
    step();
    check("t1_result", rsp_result, 32'h3f000000);
    check("t1_id", rsp_id, 0);
    lv[0] = 0; drive();
    step();

    // All lanes valid, full throughput from pointer 0.
    do_reset();
    for (int i = 0; i < N; i++) begin
      lv[i] = 1; la[i] = 32'h3f800000; lb[i] = t2_b[i];
    end
    drive();
    for (int k = 0; k < 8; k++) begin
      step();
      check("t2_grant", obs_ready, 4'b0001 << (k % 4));
      check("t2_result", rsp_result, t2_res[k % 4]);
    end
    for (int i = 0; i < N; i++) lv[i] = 0;
    drive();
    step();

    // Backpressure with lane 3 waiting behind lane 2.
    lv[2] = 1; la[2] = 32'hbf800000; lb[2] = 32'h3f000000;
    lv[3] = 1; la[3] = 32'h40400000; lb[3] = 32'h3f800000;
    rsp_ready = 1'b0;
    drive();
    step();
    lv[2] = 0; drive();
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_result", rsp_result, 32'hc0000000);
      check("t3_id", rsp_id, 2);
      check("t3_stall_ready", obs_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    check("t3_refill_grant", obs_ready, 4'b1000);
    lv[3] = 0; drive();
    step();

    // Divide by negative zero.
    lv[0] = 1; la[0] = 32'h3f800000; lb[0] = 32'h80000000;
    drive();
    step();
    check("t4_dz", rsp_dz, 1);
    check("t4_result", rsp_result, 32'hff800000);
    lv[0] = 0; drive();
    step();

    // Lanes 1 and 3 only: alternation and wrap of the pointer.
    do_reset();
    lv[1] = 1; la[1] = 32'h40a00000; lb[1] = 32'h40000000;
    lv[3] = 1; la[3] = 32'hc1200000; lb[3] = 32'h40800000;
    drive();
    for (int k = 0; k < 4; k++) begin
      step();
      check("t5_grant", obs_ready, 4'b0001 << t5_ord[k]);
      if (t5_ord[k] == 3) check("t5_rr_ptr", dut.rr_ptr, 0);
    end
    lv[1] = 0; lv[3] = 0; drive();
    step();

    // Asynchronous reset while holding a response.
    lv[2] = 1; la[2] = 32'h3fc00000; lb[2] = 32'h3f800000;
    drive();
    step();
    lv[2] = 0; drive();
    rsp_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_async_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    lv[0] = 1; la[0] = 32'h40000000; lb[0] = 32'h40400000;
    lv[1] = 1; la[1] = 32'h3f800000; lb[1] = 32'h40400000;
    drive();
    rst_n = 1'b1;
    step();
    check("t6_first_grant", obs_ready, 4'b0001);
    lv[0] = 0; drive();
    step();
    lv[1] = 0; drive();
    step();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!lv[i] && $urandom_range(0, 2) == 0) begin
          lv[i] = 1; la[i] = rand_fp(); lb[i] = rand_fp();
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      drive();
      step();
      if (last_grant >= 0) begin
        lv[last_grant] = ($urandom_range(0, 1) == 1);
        la[last_grant] = rand_fp();
        lb[last_grant] = rand_fp();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
